// File: rtl/abr_ram512x4_arb_if.sv
// Requester and RAM-port bundle for the two-requester RAM arbiter.
// slave is the arbiter side; master is the requester/RAM side.
interface abr_ram512x4_arb_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 9
);
   logic                  a_req_i;
   logic                  a_we_i;
   logic [ADDR_WIDTH-1:0] a_addr_i;
   logic [DATA_WIDTH-1:0] a_wdata_i;
   logic                  a_gnt_o;
   logic                  a_rvalid_o;
   logic [DATA_WIDTH-1:0] a_rdata_o;

   logic                  b_req_i;
   logic                  b_we_i;
   logic [ADDR_WIDTH-1:0] b_addr_i;
   logic [DATA_WIDTH-1:0] b_wdata_i;
   logic                  b_gnt_o;
   logic                  b_rvalid_o;
   logic [DATA_WIDTH-1:0] b_rdata_o;

   logic                  ram_we_o;
   logic [ADDR_WIDTH-1:0] ram_waddr_o;
   logic [DATA_WIDTH-1:0] ram_wdata_o;
   logic                  ram_re_o;
   logic [ADDR_WIDTH-1:0] ram_raddr_o;
   logic [DATA_WIDTH-1:0] ram_rdata_i;

   modport slave (
      input  a_req_i, a_we_i, a_addr_i, a_wdata_i,
      output a_gnt_o, a_rvalid_o, a_rdata_o,
      input  b_req_i, b_we_i, b_addr_i, b_wdata_i,
      output b_gnt_o, b_rvalid_o, b_rdata_o,
      output ram_we_o, ram_waddr_o, ram_wdata_o, ram_re_o, ram_raddr_o,
      input  ram_rdata_i
   );

   modport master (
      output a_req_i, a_we_i, a_addr_i, a_wdata_i,
      input  a_gnt_o, a_rvalid_o, a_rdata_o,
      output b_req_i, b_we_i, b_addr_i, b_wdata_i,
      input  b_gnt_o, b_rvalid_o, b_rdata_o,
      input  ram_we_o, ram_waddr_o, ram_wdata_o, ram_re_o, ram_raddr_o,
      output ram_rdata_i
   );
endinterface

// File: rtl/abr_ram512x4_arb.sv
// Two-requester arbiter for a 1R1W RAM with independent read/write round-robin
// channels and a zeroize sequence that clears every word one per cycle.
module abr_ram512x4_arb #(
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_b,
   input  logic                  zeroize_i,
   output logic                  busy_o,
   abr_ram512x4_arb_if.slave     bus
);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   // Pointer value 0 favours A, 1 favours B.
   logic                  wptr_q, wptr_d;
   logic                  rptr_q, rptr_d;
   logic                  a_rv_q, b_rv_q;

   logic a_wgnt, b_wgnt, a_rgnt, b_rgnt;
   logic a_wc, b_wc, a_rc, b_rc;

   assign a_wc = bus.a_req_i &  bus.a_we_i;
   assign b_wc = bus.b_req_i &  bus.b_we_i;
   assign a_rc = bus.a_req_i & ~bus.a_we_i;
   assign b_rc = bus.b_req_i & ~bus.b_we_i;

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      wptr_d          = wptr_q;
      rptr_d          = rptr_q;
      a_wgnt          = 1'b0;
      b_wgnt          = 1'b0;
      a_rgnt          = 1'b0;
      b_rgnt          = 1'b0;
      bus.ram_we_o    = 1'b0;
      bus.ram_waddr_o = '0;
      bus.ram_wdata_o = '0;
      bus.ram_re_o    = 1'b0;
      bus.ram_raddr_o = '0;
      if (rst_b) begin
         unique case (state_q)
            StIdle: begin
               if (zeroize_i) begin
                  state_d = StClear;
                  cnt_d   = '0;
               end else begin
                  a_wgnt = a_wc & (~b_wc | ~wptr_q);
                  b_wgnt = b_wc & (~a_wc |  wptr_q);
                  a_rgnt = a_rc & (~b_rc | ~rptr_q);
                  b_rgnt = b_rc & (~a_rc |  rptr_q);
                  if (a_wgnt | b_wgnt) wptr_d = a_wgnt;
                  if (a_rgnt | b_rgnt) rptr_d = a_rgnt;
                  if (a_wgnt) begin
                     bus.ram_we_o    = 1'b1;
                     bus.ram_waddr_o = bus.a_addr_i;
                     bus.ram_wdata_o = bus.a_wdata_i;
                  end else if (b_wgnt) begin
                     bus.ram_we_o    = 1'b1;
                     bus.ram_waddr_o = bus.b_addr_i;
                     bus.ram_wdata_o = bus.b_wdata_i;
                  end
                  if (a_rgnt) begin
                     bus.ram_re_o    = 1'b1;
                     bus.ram_raddr_o = bus.a_addr_i;
                  end else if (b_rgnt) begin
                     bus.ram_re_o    = 1'b1;
                     bus.ram_raddr_o = bus.b_addr_i;
                  end
               end
            end
            StClear: begin
               bus.ram_we_o    = 1'b1;
               bus.ram_waddr_o = cnt_q;
               cnt_d           = cnt_q + ADDR_WIDTH'(1);
               if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_b) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         wptr_q  <= 1'b0;
         rptr_q  <= 1'b0;
         a_rv_q  <= 1'b0;
         b_rv_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         // Not gated by state: a read granted just before CLEAR still completes.
         a_rv_q  <= a_rgnt;
         b_rv_q  <= b_rgnt;
      end
   end

   assign busy_o         = (state_q == StClear);
   assign bus.a_gnt_o    = a_wgnt | a_rgnt;
   assign bus.b_gnt_o    = b_wgnt | b_rgnt;
   assign bus.a_rvalid_o = a_rv_q;
   assign bus.b_rvalid_o = b_rv_q;
   assign bus.a_rdata_o  = bus.ram_rdata_i;
   assign bus.b_rdata_o  = bus.ram_rdata_i;

endmodule
